// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button event path.
package button_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESSED   = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_GAP       = 3'd3,
    ST_PRESSED2  = 3'd4
  } state_t;

  localparam int LONG_TICKS_DEF   = 100;
  localparam int DCLICK_TICKS_DEF = 30;
  localparam int CNT_W_DEF        = 8;

endpackage

// File: rtl/press_classifier_if.sv
// Button level/tick in, classified one-cycle event pulses out.
interface press_classifier_if;
  logic db;
  logic tick;
  logic press;
  logic short_press;
  logic long_press;
  logic double_click;
  logic busy;

  modport master (
    output db, tick,
    input  press, short_press, long_press, double_click, busy
  );

  modport slave (
    input  db, tick,
    output press, short_press, long_press, double_click, busy
  );
endinterface

// File: rtl/edge_detect.sv
// Rise/fall detector for a level already synchronous to clk.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic r_d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_d_q <= 1'b0;
    else          r_d_q <= d;
  end

  assign rise = d & ~r_d_q;
  assign fall = ~d & r_d_q;

endmodule

// File: rtl/press_classifier.sv
// Turns a debounced button level into press / short / long / double-click pulses.
//
// state        | meaning
// ST_IDLE      | button released, nothing pending
// ST_PRESSED   | first press held, timing towards long
// ST_LONG_HELD | long already reported, waiting for release
// ST_GAP       | short release, waiting for a second press
// ST_PRESSED2  | second press held, double click on release
module press_classifier
  import button_pkg::*;
#(
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int DCLICK_TICKS = DCLICK_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  press_classifier_if.slave  bus
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic w_rise;
  logic w_fall;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             r_short;
  logic             r_long;
  logic             r_dbl;
  logic             r_busy;

  edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.db),
    .rise    (w_rise),
    .fall    (w_fall)
  );

  // Transitions later in the block override the default count step,
  // so cnt restarts from zero on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_dbl   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_dbl   <= 1'b0;
      if (bus.tick && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
            r_press <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_PRESSED: begin
          if (w_fall) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
          end else if (bus.tick && r_cnt == LONG_LAST) begin
            r_state <= ST_LONG_HELD;
            r_cnt   <= '0;
            r_long  <= 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        ST_GAP: begin
          if (w_rise) begin
            r_state <= ST_PRESSED2;
            r_cnt   <= '0;
            r_press <= 1'b1;
          end else if (bus.tick && r_cnt == DCLICK_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_short <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_PRESSED2: begin
          // A second hold that goes long discards the whole pair.
          if (w_fall) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dbl   <= 1'b1;
            r_busy  <= 1'b0;
          end else if (bus.tick && r_cnt == LONG_LAST) begin
            r_state <= ST_LONG_HELD;
            r_cnt   <= '0;
            r_long  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press        = r_press;
  assign bus.short_press  = r_short;
  assign bus.long_press   = r_long;
  assign bus.double_click = r_dbl;
  assign bus.busy         = r_busy;

endmodule
